// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, inst}, multi-lane push/pop, one-cycle flush.
// Optional same-cycle bypass of pushes into an empty queue when FETCHQ_BYPASS_EN is defined.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

module fetch_queue #(
    parameter int ADDR        = `AddrWidth,
    parameter int INST        = `InstWidth,
    parameter int FETCH_WIDTH = 2,
    parameter int DEC_WIDTH   = 2,
    parameter int DEPTH       = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush_,
    input  logic                               fetch_e_,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]   fetch_cnt,
    input  logic [ADDR-1:0]                    fetch_pc,
    input  logic [FETCH_WIDTH*INST-1:0]        fetch_inst,
    output logic                               fq_ready_,
    output logic [DEC_WIDTH-1:0]               inst_e_,
    output logic [DEC_WIDTH*ADDR-1:0]          inst_pc,
    output logic [DEC_WIDTH*INST-1:0]          inst,
    input  logic [$clog2(DEC_WIDTH+1)-1:0]     dec_cnt,
    output logic [$clog2(DEPTH+1)-1:0]         fq_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    logic [ADDR-1:0] pc_mem   [DEPTH];
    logic [INST-1:0] inst_mem [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          bypass;
    int            push_n, pop_n, skip_n, nvalid;

    assign fq_ready_ = (DEPTH - int'(count_q)) < FETCH_WIDTH;
    assign fq_count  = count_q;

    always_comb begin
        push_n = 0;
        if (!fetch_e_ && !fq_ready_ && fetch_cnt != '0)
            push_n = min2(int'(fetch_cnt), FETCH_WIDTH);
        bypass = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        bypass = (count_q == '0) && (push_n > 0) && flush_;
`endif
        nvalid = bypass ? min2(push_n, DEC_WIDTH) : min2(int'(count_q), DEC_WIDTH);
        // Over-consumption is clamped to what is actually presented
        pop_n  = min2(int'(dec_cnt), nvalid);
        // Bypassed lanes consumed this cycle never enter storage
        skip_n = bypass ? pop_n : 0;
        head_d  = head_q + PW'(bypass ? 0 : pop_n);
        tail_d  = tail_q + PW'(push_n - skip_n);
        count_d = count_q + CW'(push_n) - CW'(pop_n);
        if (!flush_) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (flush_ && !reset) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (i >= skip_n && i < push_n) begin
                    pc_mem[tail_q + PW'(i - skip_n)]   <= fetch_pc + ADDR'(4 * i);
                    inst_mem[tail_q + PW'(i - skip_n)] <= fetch_inst[i*INST +: INST];
                end
            end
        end
    end

    always_comb begin
        inst_e_ = '1;
        inst_pc = '0;
        inst    = '0;
        for (int j = 0; j < DEC_WIDTH; j++) begin
            if (j < nvalid) begin
                inst_e_[j] = 1'b0;
                if (bypass) begin
                    inst_pc[j*ADDR +: ADDR] = fetch_pc + ADDR'(4 * j);
                    inst[j*INST +: INST]    = fetch_inst[((j < FETCH_WIDTH) ? j : 0)*INST +: INST];
                end else begin
                    inst_pc[j*ADDR +: ADDR] = pc_mem[head_q + PW'(j)];
                    inst[j*INST +: INST]    = inst_mem[head_q + PW'(j)];
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && flush_)
            assert (int'(dec_cnt) <= nvalid)
            else $warning("dec_cnt %0d exceeds %0d valid lanes, clamped", dec_cnt, nvalid);
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build): push/pop, full/drop, wrap, flush, clamp, async reset.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush_;
    logic        fetch_e_;
    logic [1:0]  fetch_cnt;
    logic [31:0] fetch_pc;
    logic [63:0] fetch_inst;
    logic        fq_ready_;
    logic [1:0]  inst_e_;
    logic [63:0] inst_pc;
    logic [63:0] inst;
    logic [1:0]  dec_cnt;
    logic [3:0]  fq_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_head, next_pc;

    fetch_queue dut (
        .clk(clk), .reset(reset), .flush_(flush_), .fetch_e_(fetch_e_),
        .fetch_cnt(fetch_cnt), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
        .fq_ready_(fq_ready_), .inst_e_(inst_e_), .inst_pc(inst_pc), .inst(inst),
        .dec_cnt(dec_cnt), .fq_count(fq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_e_  = 1'b1;
        fetch_cnt = 2'd0;
        dec_cnt   = 2'd0;
        flush_    = 1'b1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [1:0] cnt,
                        input logic [31:0] a, input logic [31:0] b);
        fetch_e_   = 1'b0;
        fetch_cnt  = cnt;
        fetch_pc   = pc;
        fetch_inst = {b, a};
    endtask

    initial begin
        reset = 1'b1;
        fetch_pc = '0;
        fetch_inst = '0;
        idle();
        #2;
        chk("rst_count", 64'(fq_count), 64'd0);
        chk("rst_ready", 64'(fq_ready_), 64'd0);
        chk("rst_inst_e", 64'(inst_e_), 64'b11);
        chk("rst_pc", inst_pc, 64'd0);
        chk("rst_inst", inst, 64'd0);
        #10 reset = 1'b0;

        // first push visible next cycle
        push(32'h100, 2'd2, 32'h1111_0000, 32'h2222_0000);
        tick(); idle();
        chk("p1_inst_e", 64'(inst_e_), 64'b00);
        chk("p1_pc", inst_pc, {32'h104, 32'h100});
        chk("p1_inst", inst, {32'h2222_0000, 32'h1111_0000});
        chk("p1_count", 64'(fq_count), 64'd2);
        chk("p1_ready", 64'(fq_ready_), 64'd0);

        // fill to 8
        for (int k = 1; k < 4; k++) begin
            push(32'h100 + 32'(8 * k), 2'd2, 32'hA0 + 32'(k), 32'hB0 + 32'(k));
            tick();
        end
        idle();
        chk("full_count", 64'(fq_count), 64'd8);
        chk("full_ready", 64'(fq_ready_), 64'd1);

        // push into full queue is dropped
        push(32'h900, 2'd2, 32'hDEAD, 32'hBEEF);
        tick(); idle();
        chk("drop_count", 64'(fq_count), 64'd8);
        chk("drop_pc", inst_pc, {32'h104, 32'h100});

        // pop one: count 7 still not ready
        dec_cnt = 2'd1;
        tick(); idle();
        chk("c7_count", 64'(fq_count), 64'd7);
        chk("c7_ready", 64'(fq_ready_), 64'd1);
        chk("c7_pc", inst_pc, {32'h108, 32'h104});

        // pop 2 / push 2 across pointer wrap
        exp_head = 32'h104;
        next_pc  = 32'h120;
        for (int it = 0; it < 4; it++) begin
            chk("wrap_pc", inst_pc, {exp_head + 32'd4, exp_head});
            dec_cnt = 2'd2;
            tick(); idle();
            push(next_pc, 2'd2, next_pc, next_pc + 32'd4);
            tick(); idle();
            exp_head = exp_head + 32'd8;
            next_pc  = next_pc + 32'd8;
            chk("wrap_count", 64'(fq_count), 64'd7);
        end
        chk("wrap_end_pc", inst_pc, {32'h128, 32'h124});

        // simultaneous push and pop
        dec_cnt = 2'd2;
        tick(); idle();
        push(32'h140, 2'd2, 32'h140, 32'h144);
        dec_cnt = 2'd2;
        tick(); idle();
        chk("pp_count", 64'(fq_count), 64'd5);
        chk("pp_pc", inst_pc, {32'h138, 32'h134});

        // flush with concurrent push and pop
        flush_ = 1'b0;
        push(32'h500, 2'd2, 32'h55, 32'h56);
        dec_cnt = 2'd1;
        tick(); idle();
        chk("fl_count", 64'(fq_count), 64'd0);
        chk("fl_inst_e", 64'(inst_e_), 64'b11);
        chk("fl_pc", inst_pc, 64'd0);
        push(32'h600, 2'd2, 32'h66, 32'h67);
        tick(); idle();
        chk("afl_pc", inst_pc, {32'h604, 32'h600});
        chk("afl_count", 64'(fq_count), 64'd2);

        // single-lane push with one pop
        push(32'h700, 2'd1, 32'h77, 32'hFF);
        dec_cnt = 2'd1;
        tick(); idle();
        chk("p1l_count", 64'(fq_count), 64'd2);
        chk("p1l_pc", inst_pc, {32'h700, 32'h604});
        chk("p1l_inst", inst, {32'h77, 32'h67});

        dec_cnt = 2'd1;
        tick(); idle();
        chk("one_count", 64'(fq_count), 64'd1);
        chk("one_inst_e", 64'(inst_e_), 64'b10);
        chk("one_pc", inst_pc, {32'h0, 32'h700});

        // over-consume: clamped to one
        dec_cnt = 2'd2;
        tick(); idle();
        chk("clamp_count", 64'(fq_count), 64'd0);
        chk("clamp_inst_e", 64'(inst_e_), 64'b11);

        // fetch_cnt = 0 is a no-op
        push(32'hA00, 2'd0, 32'h1, 32'h2);
        tick(); idle();
        chk("cnt0_count", 64'(fq_count), 64'd0);

        push(32'h800, 2'd2, 32'h88, 32'h89);
        tick(); idle();
        chk("post_clamp_pc", inst_pc, {32'h804, 32'h800});
        chk("post_clamp_count", 64'(fq_count), 64'd2);

        // asynchronous reset mid-operation
        #2 reset = 1'b1;
        #1;
        chk("arst_count", 64'(fq_count), 64'd0);
        chk("arst_inst_e", 64'(inst_e_), 64'b11);
        chk("arst_pc", inst_pc, 64'd0);
        #1 reset = 1'b0;
        tick();
        chk("arst_hold", 64'(fq_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
